rdcla_pipe: RTL and testbench

RDCLA_PIPE -- requirements
Module: rdcla_pipe

---
 rtl/rdcla_pkg.sv | 20 ++
 rtl/kpg_merge.sv | 12 +
 rtl/rdcla_pipe.sv | 130 +++++++++++++
 tb/tb_rdcla_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rdcla_pkg.sv
// rtl/rdcla_pkg.sv - shared kpg encoding constants and width helper for the prefix adder
package rdcla_pkg;

    typedef logic [1:0] kpg_t;

    // Encoded as {c1,c0}: c1 = a|b, c0 = a&b, so a resolved position's carry is c1.
    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_PROP = 2'b10;
    localparam kpg_t KPG_GEN  = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kpg_merge.sv
// rtl/kpg_merge.sv - combine a higher kpg span with the adjacent lower span
module kpg_merge
    import rdcla_pkg::*;
(
    input  kpg_t i_hi,
    input  kpg_t i_lo,
    output kpg_t o_kpg
);

    assign o_kpg = (i_hi == KPG_PROP) ? i_lo : i_hi;

endmodule

// File: rtl/rdcla_pipe.sv
// rtl/rdcla_pipe.sv - pipelined recursive-doubling carry-lookahead adder/subtractor
module rdcla_pipe
    import rdcla_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = clog2(WIDTH);
    localparam int NPOS   = WIDTH + 1;

    logic                  w_stall;
    logic                  w_en;
    logic [WIDTH-1:0]      w_b_eff;
    logic [WIDTH-1:0]      w_partial;
    logic                  w_cin_eff;
    logic [2*NPOS-1:0]     w_kpg_init;
    logic [2*NPOS-1:0]     w_stage_kpg [0:STAGES];
    logic [WIDTH-1:0]      w_carry;
    kpg_t                  w_msb_res;

    logic [STAGES:0]       r_valid;
    logic [WIDTH-1:0]      r_partial [0:STAGES];
    logic [STAGES:0]       r_a_msb;
    logic [STAGES:0]       r_b_msb;
    logic [2*NPOS-1:0]     r_kpg0;

    assign w_stall   = r_valid[STAGES] & ~out_ready;
    assign w_en      = ~w_stall;
    assign in_ready  = w_en;
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
    assign w_partial = a ^ w_b_eff;

    // Position 0 is the carry-in; position i+1 describes operand bit i.
    assign w_kpg_init[1:0] = w_cin_eff ? KPG_GEN : KPG_KILL;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
        assign w_kpg_init[2*gi+2 +: 2] = {a[gi] | w_b_eff[gi], a[gi] & w_b_eff[gi]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kpg0 <= '0;
        end else if (w_en) begin
            r_kpg0 <= w_kpg_init;
        end
    end
    assign w_stage_kpg[0] = r_kpg0;

    for (genvar k = 1; k <= STAGES; k++) begin : g_lvl
        localparam int D = 1 << (k - 1);
        logic [2*NPOS-1:0] w_merged;
        logic [2*NPOS-1:0] r_kpg;

        for (genvar i = 0; i < NPOS; i++) begin : g_pos
            if (i < D) begin : g_pass
                assign w_merged[2*i +: 2] = w_stage_kpg[k-1][2*i +: 2];
            end else begin : g_merge
                kpg_merge u_merge (
                    .i_hi  (w_stage_kpg[k-1][2*i +: 2]),
                    .i_lo  (w_stage_kpg[k-1][2*(i-D) +: 2]),
                    .o_kpg (w_merged[2*i +: 2])
                );
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_kpg <= '0;
            end else if (w_en) begin
                r_kpg <= w_merged;
            end
        end
        assign w_stage_kpg[k] = r_kpg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_a_msb <= '0;
            r_b_msb <= '0;
            for (int s = 0; s <= STAGES; s++) begin
                r_partial[s] <= '0;
            end
        end else if (w_en) begin
            r_valid[0]   <= in_valid;
            r_partial[0] <= w_partial;
            r_a_msb[0]   <= a[WIDTH-1];
            r_b_msb[0]   <= w_b_eff[WIDTH-1];
            for (int s = 1; s <= STAGES; s++) begin
                r_valid[s]   <= r_valid[s-1];
                r_partial[s] <= r_partial[s-1];
                r_a_msb[s]   <= r_a_msb[s-1];
                r_b_msb[s]   <= r_b_msb[s-1];
            end
        end
    end

    // Below the MSB every span reaches the carry-in, so no position is left as PROP.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
        assign w_carry[gi] = (w_stage_kpg[STAGES][2*gi +: 2] == KPG_GEN);
    end

    // The top position spans only WIDTH bits; fold in the carry-in slot to finish it.
    kpg_merge u_cout (
        .i_hi  (w_stage_kpg[STAGES][2*WIDTH +: 2]),
        .i_lo  (w_stage_kpg[STAGES][1:0]),
        .o_kpg (w_msb_res)
    );

    assign out_valid = r_valid[STAGES];
    assign sum       = r_partial[STAGES] ^ w_carry;
    assign cout      = w_msb_res[1];
    assign ovf       = (r_a_msb[STAGES] == r_b_msb[STAGES]) & (sum[WIDTH-1] != r_a_msb[STAGES]);

endmodule

// File: tb/tb_rdcla_pipe.sv
// tb/tb_rdcla_pipe.sv - scoreboard bench for rdcla_pipe at widths 32, 8 and 64
module tb_rdcla_pipe;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
        int          stl;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, cin, sub, out_ready;
    logic [63:0] a, b;
    logic        rdy32, rdy8, rdy64, ov32, ov8, ov64;
    logic        co32, co8, co64, of32, of8, of64;
    logic [31:0] s32;
    logic [7:0]  s8;
    logic [63:0] s64;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   stl32 = 0;
    bit   held_valid = 0;
    bit   chk_stall = 0;
    exp_t held;
    exp_t none;
    exp_t q32[$];
    exp_t q8[$];
    exp_t q64[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    rdcla_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32)
    );

    rdcla_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(1'b1), .sum(s8), .cout(co8), .ovf(of8)
    );

    rdcla_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov64), .out_ready(1'b1), .sum(s64), .cout(co64), .ovf(of64)
    );

    function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic sb);
        exp_t        m;
        logic [63:0] mask, be;
        logic [64:0] full;
        mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        be     = (sb ? ~y : y) & mask;
        full   = {1'b0, x & mask} + {1'b0, be} + {64'd0, (sb | ci)};
        m.sum  = full[63:0] & mask;
        m.cout = full[w];
        m.ovf  = (x[w-1] == be[w-1]) && (m.sum[w-1] != x[w-1]);
        m.cyc  = 0;
        m.stl  = 0;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: result emitted with empty scoreboard (cycle %0d)", name, cyc);
    endtask

    // One cycle: sample at negedge, score emits and accepts, advance past the next posedge.
    task automatic step(input exp_t e32);
        exp_t x;
        @(negedge clk);
        if (held_valid) begin
            check("held_sum", 64'(s32), held.sum);
            check("held_cout", 64'(co32), 64'(held.cout));
            check("held_ovf", 64'(of32), 64'(held.ovf));
        end
        if (chk_stall) begin
            check("stall_in_ready", 64'(rdy32), 64'd0);
            check("stall_out_valid", 64'(ov32), 64'd1);
        end
        if (ov32 && !out_ready) begin
            stl32++;
            held_valid = 1;
            held.sum   = 64'(s32);
            held.cout  = co32;
            held.ovf   = of32;
        end else begin
            held_valid = 0;
        end
        if (ov32 && out_ready) begin
            if (q32.size() == 0) unexpected("w32_out");
            else begin
                x = q32.pop_front();
                check("w32_sum", 64'(s32), x.sum);
                check("w32_cout", 64'(co32), 64'(x.cout));
                check("w32_ovf", 64'(of32), 64'(x.ovf));
                check("w32_latency", 64'(cyc - x.cyc), 64'(6 + stl32 - x.stl));
            end
        end
        if (ov8) begin
            if (q8.size() == 0) unexpected("w8_out");
            else begin
                x = q8.pop_front();
                check("w8_sum", 64'(s8), x.sum);
                check("w8_flags", {62'd0, co8, of8}, {62'd0, x.cout, x.ovf});
                check("w8_latency", 64'(cyc - x.cyc), 64'd4);
            end
        end
        if (ov64) begin
            if (q64.size() == 0) unexpected("w64_out");
            else begin
                x = q64.pop_front();
                check("w64_sum", s64, x.sum);
                check("w64_flags", {62'd0, co64, of64}, {62'd0, x.cout, x.ovf});
                check("w64_latency", 64'(cyc - x.cyc), 64'd7);
            end
        end
        if (in_valid && rdy32) begin
            x = e32; x.cyc = cyc; x.stl = stl32;
            q32.push_back(x);
        end
        if (in_valid && rdy8) begin
            x = model(8, a, b, cin, sub); x.cyc = cyc;
            q8.push_back(x);
        end
        if (in_valid && rdy64) begin
            x = model(64, a, b, cin, sub); x.cyc = cyc;
            q64.push_back(x);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int n);
        in_valid  = 0;
        out_ready = 1;
        for (int i = 0; i < n; i++) step(none);
    endtask

    task automatic drive_random(input bit valid);
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        in_valid = valid;
    endtask

    initial begin
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[4] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[9] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};

        none = '{64'd0, 1'b0, 1'b0, 0, 0};
        held = none;
        rst = 1; in_valid = 0; out_ready = 1; a = '0; b = '0; cin = 0; sub = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(ov32), 64'd0);
        check("rst_in_ready", 64'(rdy32), 64'd1);
        check("rst_sum", 64'(s32), 64'd0);
        check("rst_flags", {62'd0, co32, of32}, 64'd0);
        check("rst_valid_w8_w64", {62'd0, ov8, ov64}, 64'd0);
        @(posedge clk);
        #1 rst = 0;

        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            a = {32'd0, tbl[i].a}; b = {32'd0, tbl[i].b};
            cin = tbl[i].cin; sub = tbl[i].sub; in_valid = 1;
            step('{{32'd0, tbl[i].sum}, tbl[i].cout, tbl[i].ovf, 0, 0});
        end
        drain(10);

        for (int i = 0; i < 100; i++) begin
            drive_random(1);
            step(model(32, a, b, cin, sub));
        end
        drain(10);

        for (int i = 0; i < 16; i++) begin
            drive_random(1);
            out_ready = !(i >= 7 && i <= 10);
            chk_stall = (i >= 8 && i <= 10);
            step(model(32, a, b, cin, sub));
        end
        chk_stall = 0;
        drain(10);

        for (int i = 0; i < 150; i++) begin
            drive_random($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            step(model(32, a, b, cin, sub));
        end
        drain(12);

        for (int i = 0; i < 3; i++) begin
            drive_random(1);
            step(model(32, a, b, cin, sub));
        end
        in_valid = 0;
        for (int i = 0; i < 3; i++) step(none);
        #2 rst = 1;
        #1;
        check("midrst_out_valid", 64'(ov32), 64'd0);
        check("midrst_in_ready", 64'(rdy32), 64'd1);
        check("midrst_sum", 64'(s32), 64'd0);
        check("midrst_w64_valid", 64'(ov64), 64'd0);
        q32.delete(); q8.delete(); q64.delete();
        held_valid = 0;
        @(posedge clk);
        #1 rst = 0;
        drain(12);

        check("final_q32_empty", 64'(q32.size()), 64'd0);
        check("final_q8_empty", 64'(q8.size()), 64'd0);
        check("final_q64_empty", 64'(q64.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
